// File: rtl/psum_ofifo_pkg.sv
// Shared defaults and width helpers for the partial-sum output FIFO.
// Pointer and count widths are derived here so every column agrees on them.
package psum_ofifo_pkg;

   localparam int DEF_COL       = 8;
   localparam int DEF_PSUM_BW   = 16;
   localparam int DEF_DEPTH     = 64;
   localparam int DEF_AF_THRESH = DEF_DEPTH - 4;

   // Pointer indexes DEPTH entries; DEPTH is a power of two, so the pointer wraps on its own.
   function automatic int ptr_w(input int depth);
      return (depth > 1) ? $clog2(depth) : 1;
   endfunction

   // The count must represent 0..DEPTH inclusive, which needs one more bit than the pointer.
   function automatic int cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/psum_ofifo_col.sv
// One column of the partial-sum FIFO: storage, write/read pointers, occupancy
// and the write-accept decision. The row pop decision is made by the top.
module psum_ofifo_col
   import psum_ofifo_pkg::*;
#(
   parameter int PSUM_BW   = DEF_PSUM_BW,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEF_AF_THRESH
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      wr,
   input  logic [PSUM_BW-1:0]        din,
   input  logic                      pop,
   output logic [PSUM_BW-1:0]        dout,
   output logic [cnt_w(DEPTH)-1:0]   count,
   output logic                      empty,
   output logic                      full,
   output logic                      almost_full,
   output logic                      overflow_evt
);

   localparam int PW = ptr_w(DEPTH);
   localparam int CW = cnt_w(DEPTH);

   logic [PSUM_BW-1:0] mem [DEPTH];
   logic [PW-1:0]      wr_ptr;
   logic [PW-1:0]      rd_ptr;
   logic               wr_ok;

   assign empty       = (count == '0);
   assign full        = (count == CW'(DEPTH));
   assign almost_full = (count >= CW'(AF_THRESH));

   // A full column still takes a write when the same cycle pops a row out of it.
   assign wr_ok        = wr && (!full || pop);
   assign overflow_evt = wr && !wr_ok;

   assign dout = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (wr_ok) begin
         mem[wr_ptr] <= din;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (wr_ok) begin
            wr_ptr <= wr_ptr + PW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + PW'(1);
         end
         unique case ({wr_ok, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
      end
   end

endmodule

// File: rtl/psum_ofifo.sv
// Partial-sum output FIFO: COL independently written columns popped as whole rows.
// Holds the row-pop decision, the registered output row, status reduction and sticky errors.
module psum_ofifo
   import psum_ofifo_pkg::*;
#(
   parameter int COL       = DEF_COL,
   parameter int PSUM_BW   = DEF_PSUM_BW,
   parameter int DEPTH     = DEF_DEPTH,
   parameter int AF_THRESH = DEPTH - 4
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic [COL-1:0]             wr,
   input  logic [PSUM_BW*COL-1:0]     in,
   input  logic                       rd,
   input  logic                       clr_err,
   output logic [PSUM_BW*COL-1:0]     out,
   output logic                       out_valid,
   output logic                       o_valid,
   output logic                       o_full,
   output logic                       o_ready,
   output logic                       o_almost_full,
   output logic [cnt_w(DEPTH)-1:0]    o_row_count,
   output logic                       o_overflow,
   output logic                       o_underflow
);

   localparam int CW = cnt_w(DEPTH);

   logic [COL-1:0]              empty_vec;
   logic [COL-1:0]              full_vec;
   logic [COL-1:0]              af_vec;
   logic [COL-1:0]              ovf_vec;
   logic [COL-1:0][CW-1:0]      cnt_vec;
   logic [COL-1:0][PSUM_BW-1:0] rdata;
   logic [CW-1:0]               row_min;
   logic                        pop_ok;
   logic                        underflow_evt;
   logic [PSUM_BW*COL-1:0]      row_p1;
   logic                        vld_p1;
   logic                        overflow_q;
   logic                        underflow_q;

   for (genvar i = 0; i < COL; i++) begin : g_col
      psum_ofifo_col #(
         .PSUM_BW   (PSUM_BW),
         .DEPTH     (DEPTH),
         .AF_THRESH (AF_THRESH)
      ) u_col (
         .clk          (clk),
         .reset        (reset),
         .wr           (wr[i]),
         .din          (in[PSUM_BW*i +: PSUM_BW]),
         .pop          (pop_ok),
         .dout         (rdata[i]),
         .count        (cnt_vec[i]),
         .empty        (empty_vec[i]),
         .full         (full_vec[i]),
         .almost_full  (af_vec[i]),
         .overflow_evt (ovf_vec[i])
      );
   end

   // Status comes only from registered counts, so a same-cycle write never makes a row poppable.
   assign o_valid       = ~|empty_vec;
   assign o_full        = |full_vec;
   assign o_ready       = ~o_full;
   assign o_almost_full = |af_vec;
   assign pop_ok        = rd & o_valid;
   assign underflow_evt = rd & ~o_valid;

   always_comb begin
      row_min = cnt_vec[0];
      for (int i = 1; i < COL; i++) begin
         if (cnt_vec[i] < row_min) begin
            row_min = cnt_vec[i];
         end
      end
   end

   assign o_row_count = row_min;

   // Stage p1: popped row registered one cycle after acceptance; held while no pop.
   always_ff @(posedge clk) begin
      if (reset) begin
         row_p1 <= '0;
         vld_p1 <= 1'b0;
      end else begin
         vld_p1 <= pop_ok;
         if (pop_ok) begin
            row_p1 <= rdata;
         end
      end
   end

   assign out       = row_p1;
   assign out_valid = vld_p1;

   // A new error event in the clearing cycle keeps the flag set.
   always_ff @(posedge clk) begin
      if (reset) begin
         overflow_q  <= 1'b0;
         underflow_q <= 1'b0;
      end else begin
         if (|ovf_vec) begin
            overflow_q <= 1'b1;
         end else if (clr_err) begin
            overflow_q <= 1'b0;
         end
         if (underflow_evt) begin
            underflow_q <= 1'b1;
         end else if (clr_err) begin
            underflow_q <= 1'b0;
         end
      end
   end

   assign o_overflow  = overflow_q;
   assign o_underflow = underflow_q;

endmodule

// File: tb/tb_psum_ofifo.sv
// Bench for psum_ofifo: table vectors, directed corner sequences and a random
// phase, all compared against a queue-per-column reference model.
module tb_psum_ofifo;

   localparam int COL   = 8;
   localparam int BW    = 16;
   localparam int DEPTH = 64;
   localparam int AF    = DEPTH - 4;
   localparam int CW    = $clog2(DEPTH) + 1;
   localparam int DW    = COL * BW;

   logic          clk = 1'b0;
   logic          reset;
   logic [COL-1:0] wr;
   logic [DW-1:0] in;
   logic          rd;
   logic          clr_err;
   logic [DW-1:0] out;
   logic          out_valid;
   logic          o_valid;
   logic          o_full;
   logic          o_ready;
   logic          o_almost_full;
   logic [CW-1:0] o_row_count;
   logic          o_overflow;
   logic          o_underflow;

   always #5 clk = ~clk;

   psum_ofifo #(
      .COL       (COL),
      .PSUM_BW   (BW),
      .DEPTH     (DEPTH),
      .AF_THRESH (AF)
   ) dut (
      .clk           (clk),
      .reset         (reset),
      .wr            (wr),
      .in            (in),
      .rd            (rd),
      .clr_err       (clr_err),
      .out           (out),
      .out_valid     (out_valid),
      .o_valid       (o_valid),
      .o_full        (o_full),
      .o_ready       (o_ready),
      .o_almost_full (o_almost_full),
      .o_row_count   (o_row_count),
      .o_overflow    (o_overflow),
      .o_underflow   (o_underflow)
   );

   int checks   = 0;
   int failures = 0;

   // Reference model: one FIFO queue per column plus the expected registered outputs.
   logic [BW-1:0] mq [COL][$];
   logic [DW-1:0] m_out;
   logic          m_ov;
   logic          m_ovf;
   logic          m_udf;

   typedef struct {
      logic           rst;
      logic [COL-1:0] w;
      int             row;
      logic           p;
      logic           c;
      int             e_cnt;
      logic           e_valid;
      logic           e_ov;
      int             e_out;
      logic           e_udf;
   } vec_t;

   vec_t tbl [10];

   task automatic chk1(input string nm, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%b required=%b", nm, act, exp);
      end
   endtask

   task automatic chkc(input string nm, input int act, input int exp);
      checks++;
      if (act != exp) begin
         failures++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic chkd(input string nm, input logic [DW-1:0] act, input logic [DW-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", nm, act, exp);
      end
   endtask

   function automatic logic [DW-1:0] mkrow(input int v);
      logic [DW-1:0] r;
      r = '0;
      if (v != 0) begin
         for (int i = 0; i < COL; i++) begin
            r[i*BW +: BW] = BW'((v << 4) + i);
         end
      end
      return r;
   endfunction

   task automatic model_step(input logic r, input logic [COL-1:0] w, input logic [DW-1:0] d,
                             input logic p, input logic c);
      bit valid;
      bit popping;
      bit ovf_e;
      valid = 1'b1;
      ovf_e = 1'b0;
      if (r) begin
         for (int i = 0; i < COL; i++) mq[i].delete();
         m_out = '0;
         m_ov  = 1'b0;
         m_ovf = 1'b0;
         m_udf = 1'b0;
         return;
      end
      for (int i = 0; i < COL; i++) if (mq[i].size() == 0) valid = 1'b0;
      popping = p && valid;
      if (popping) begin
         for (int i = 0; i < COL; i++) m_out[i*BW +: BW] = mq[i][0];
      end
      for (int i = 0; i < COL; i++) begin
         if (w[i]) begin
            if (mq[i].size() < DEPTH || popping) mq[i].push_back(d[i*BW +: BW]);
            else ovf_e = 1'b1;
         end
      end
      if (popping) begin
         for (int i = 0; i < COL; i++) void'(mq[i].pop_front());
      end
      m_ov  = popping;
      m_ovf = ovf_e ? 1'b1 : (c ? 1'b0 : m_ovf);
      m_udf = (p && !valid) ? 1'b1 : (c ? 1'b0 : m_udf);
   endtask

   task automatic check_all(input string tag);
      int mn;
      bit v;
      bit f;
      bit af;
      mn = DEPTH;
      v  = 1'b1;
      f  = 1'b0;
      af = 1'b0;
      for (int i = 0; i < COL; i++) begin
         if (mq[i].size() < mn) mn = mq[i].size();
         if (mq[i].size() == 0) v = 1'b0;
         if (mq[i].size() == DEPTH) f = 1'b1;
         if (mq[i].size() >= AF) af = 1'b1;
      end
      chkd({tag, "_out"}, out, m_out);
      chk1({tag, "_out_valid"}, out_valid, m_ov);
      chk1({tag, "_o_valid"}, o_valid, v);
      chk1({tag, "_o_full"}, o_full, f);
      chk1({tag, "_o_ready"}, o_ready, !f);
      chk1({tag, "_o_almost_full"}, o_almost_full, af);
      chkc({tag, "_row_count"}, int'(o_row_count), mn);
      chk1({tag, "_overflow"}, o_overflow, m_ovf);
      chk1({tag, "_underflow"}, o_underflow, m_udf);
   endtask

   task automatic step(input logic r, input logic [COL-1:0] w, input logic [DW-1:0] d,
                       input logic p, input logic c, input string tag);
      reset   = r;
      wr      = w;
      in      = d;
      rd      = p;
      clr_err = c;
      @(posedge clk);
      model_step(r, w, d, p, c);
      #1;
      check_all(tag);
   endtask

   initial begin
      logic [DW-1:0] held;
      logic [COL-1:0] rw;
      int wprob;
      int rprob;

      reset   = 1'b1;
      wr      = '0;
      in      = '0;
      rd      = 1'b0;
      clr_err = 1'b0;

      // rst, wr, row, rd, clr, e_cnt, e_valid, e_ov, e_out, e_udf
      tbl[0] = '{1'b1, 8'h00, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 0, 1'b0};
      tbl[1] = '{1'b0, 8'hff, 1, 1'b0, 1'b0, 1, 1'b1, 1'b0, 0, 1'b0};
      tbl[2] = '{1'b0, 8'hff, 2, 1'b0, 1'b0, 2, 1'b1, 1'b0, 0, 1'b0};
      tbl[3] = '{1'b0, 8'hff, 3, 1'b0, 1'b0, 3, 1'b1, 1'b0, 0, 1'b0};
      tbl[4] = '{1'b0, 8'h00, 0, 1'b1, 1'b0, 2, 1'b1, 1'b1, 1, 1'b0};
      tbl[5] = '{1'b0, 8'h00, 0, 1'b1, 1'b0, 1, 1'b1, 1'b1, 2, 1'b0};
      tbl[6] = '{1'b0, 8'h00, 0, 1'b1, 1'b0, 0, 1'b0, 1'b1, 3, 1'b0};
      tbl[7] = '{1'b0, 8'h00, 0, 1'b0, 1'b0, 0, 1'b0, 1'b0, 3, 1'b0};
      tbl[8] = '{1'b0, 8'h00, 0, 1'b1, 1'b0, 0, 1'b0, 1'b0, 3, 1'b1};
      tbl[9] = '{1'b0, 8'h00, 0, 1'b0, 1'b1, 0, 1'b0, 1'b0, 3, 1'b0};

      for (int k = 0; k < 10; k++) begin
         step(tbl[k].rst, tbl[k].w, mkrow(tbl[k].row), tbl[k].p, tbl[k].c, "tbl");
         chkc("tbl_row_count", int'(o_row_count), tbl[k].e_cnt);
         chk1("tbl_o_valid", o_valid, tbl[k].e_valid);
         chk1("tbl_out_valid", out_valid, tbl[k].e_ov);
         chkd("tbl_out", out, mkrow(tbl[k].e_out));
         chk1("tbl_underflow", o_underflow, tbl[k].e_udf);
      end
      chk1("tbl_reset_ready", o_ready, 1'b1);

      // Skewed column fill, then an ignored pop once column 0 runs dry.
      step(1'b1, '0, '0, 1'b0, 1'b0, "skew");
      for (int k = 1; k <= 5; k++) step(1'b0, (k <= 2) ? 8'hff : 8'hfe, mkrow(k), 1'b0, 1'b0, "skew");
      chkc("skew_row_count", int'(o_row_count), 2);
      step(1'b0, '0, '0, 1'b1, 1'b0, "skew");
      step(1'b0, '0, '0, 1'b1, 1'b0, "skew");
      held = out;
      step(1'b0, '0, '0, 1'b1, 1'b0, "skew");
      chk1("skew_underflow", o_underflow, 1'b1);
      chkd("skew_out_hold", out, held);
      chk1("skew_out_valid", out_valid, 1'b0);

      // Column 3 to full, almost-full threshold, dropped write, then write+pop on a full column.
      step(1'b1, '0, '0, 1'b0, 1'b0, "fill");
      for (int k = 1; k <= DEPTH; k++) begin
         step(1'b0, 8'h08, mkrow(k), 1'b0, 1'b0, "fill");
         if (k == AF - 1) chk1("fill_af_below", o_almost_full, 1'b0);
         if (k == AF) chk1("fill_af_at", o_almost_full, 1'b1);
      end
      chk1("fill_full", o_full, 1'b1);
      chk1("fill_ready", o_ready, 1'b0);
      step(1'b0, 8'h08, mkrow(99), 1'b0, 1'b0, "fill");
      chk1("fill_overflow", o_overflow, 1'b1);
      step(1'b0, '0, '0, 1'b0, 1'b1, "fill");
      chk1("fill_clr", o_overflow, 1'b0);
      step(1'b0, 8'hf7, mkrow(100), 1'b0, 1'b0, "fill");
      step(1'b0, 8'h08, mkrow(101), 1'b1, 1'b0, "fill");
      chk1("fullpop_full", o_full, 1'b1);
      chk1("fullpop_overflow", o_overflow, 1'b0);
      chk1("fullpop_out_valid", out_valid, 1'b1);

      // Clear with a simultaneous error keeps the flag set.
      step(1'b0, 8'h08, mkrow(102), 1'b0, 1'b0, "clrwin");
      step(1'b0, 8'h08, mkrow(103), 1'b0, 1'b1, "clrwin");
      chk1("clrwin_overflow", o_overflow, 1'b1);

      // 200 rows streamed through with pointer wrap.
      step(1'b1, '0, '0, 1'b0, 1'b0, "wrap");
      for (int k = 1; k <= 200; k++) begin
         step(1'b0, 8'hff, mkrow(k + 200), (k > 10), 1'b0, "wrap");
      end
      for (int k = 0; k < 10; k++) step(1'b0, '0, '0, 1'b1, 1'b0, "wrap");
      chk1("wrap_overflow", o_overflow, 1'b0);
      chk1("wrap_underflow", o_underflow, 1'b0);
      chkc("wrap_row_count", int'(o_row_count), 0);

      // Reset in the middle of traffic with flags set and a row in flight.
      step(1'b1, '0, '0, 1'b0, 1'b0, "midrst");
      step(1'b0, '0, '0, 1'b1, 1'b0, "midrst");
      for (int k = 1; k <= 10; k++) step(1'b0, 8'hff, mkrow(k + 50), 1'b0, 1'b0, "midrst");
      step(1'b0, 8'hff, mkrow(61), 1'b1, 1'b0, "midrst");
      step(1'b1, 8'hff, mkrow(62), 1'b1, 1'b1, "midrst");
      chkc("midrst_row_count", int'(o_row_count), 0);
      chkd("midrst_out", out, '0);
      chk1("midrst_out_valid", out_valid, 1'b0);
      chk1("midrst_underflow", o_underflow, 1'b0);
      chk1("midrst_overflow", o_overflow, 1'b0);

      // Random traffic with alternating write-heavy and read-heavy phases.
      for (int cyc = 0; cyc < 2500; cyc++) begin
         wprob = ((cyc / 250) % 2 == 0) ? 85 : 35;
         rprob = ((cyc / 250) % 2 == 0) ? 25 : 80;
         for (int i = 0; i < COL; i++) rw[i] = ($urandom_range(0, 99) < wprob);
         step(($urandom_range(0, 599) == 0), rw,
              {$urandom(), $urandom(), $urandom(), $urandom()},
              ($urandom_range(0, 99) < rprob), ($urandom_range(0, 31) == 0), "rand");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
